// File: rtl/word_buffer_ctrl.sv
// Double-buffered letter-code controller: producer fills a back buffer, the front buffer swaps at a raster-safe point.
// Optional WORD_AUTO_COMMIT_EN: writing the last slot commits the word automatically.
module word_buffer_ctrl #(
    parameter int unsigned MAX_LEN     = 10,
    parameter int unsigned CODE_W      = 6,
    parameter int unsigned BLANK_CODE  = 63,
    parameter int unsigned SWAP_HCOUNT = 0,
    parameter int unsigned SWAP_VCOUNT = 720
) (
    input  logic              pixel_clk_in,
    input  logic              rst_n_in,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    input  logic [CODE_W-1:0] char_in,
    input  logic              char_valid_in,
    output logic              char_ready_out,
    input  logic              commit_in,
    output logic [CODE_W-1:0] word_out [MAX_LEN-1:0],
    output logic [3:0]        word_len_out,
    output logic              busy_out,
    output logic              swap_out,
    output logic              overflow_out
);

    localparam logic [3:0]        MaxLen = 4'(MAX_LEN);
    localparam logic [CODE_W-1:0] Blank  = CODE_W'(BLANK_CODE);
    localparam logic [10:0]       SwapH  = 11'(SWAP_HCOUNT);
    localparam logic [9:0]        SwapV  = 10'(SWAP_VCOUNT);

    typedef enum logic [0:0] {StFill, StPending} state_e;

    state_e            state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [3:0]        plen_q, plen_d;
    logic [3:0]        len_q, len_d;
    logic [CODE_W-1:0] front_q [MAX_LEN-1:0];
    logic [CODE_W-1:0] front_d [MAX_LEN-1:0];
    logic [CODE_W-1:0] back_q  [MAX_LEN-1:0];
    logic [CODE_W-1:0] back_d  [MAX_LEN-1:0];
    logic              swap_q, swap_d;
    logic              ovf_q, ovf_d;
    logic              commit;
    logic              match;

    assign match = (hcount_in == SwapH) && (vcount_in == SwapV);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        plen_d  = plen_q;
        len_d   = len_q;
        front_d = front_q;
        back_d  = back_q;
        swap_d  = 1'b0;
        ovf_d   = ovf_q;
        commit  = 1'b0;
        unique case (state_q)
            StFill: begin
                commit = commit_in;
                if (char_valid_in) begin
                    if (idx_q < MaxLen) begin
                        back_d[idx_q] = char_in;
                        idx_d         = idx_q + 4'd1;
`ifdef WORD_AUTO_COMMIT_EN
                        if (idx_q == MaxLen - 4'd1) commit = 1'b1;
`endif
                    end else begin
`ifndef WORD_AUTO_COMMIT_EN
                        // Full buffer still consumes the char; it is dropped and flagged.
                        ovf_d = 1'b1;
`endif
                    end
                end
                // idx_d already counts a same-cycle char, so it joins the committed word.
                if (commit) begin
                    plen_d  = idx_d;
                    state_d = StPending;
                end
            end
            StPending: begin
                if (match) begin
                    front_d = back_q;
                    len_d   = plen_q;
                    for (int i = 0; i < MAX_LEN; i++) back_d[i] = Blank;
                    idx_d   = 4'd0;
                    swap_d  = 1'b1;
                    state_d = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= StFill;
            idx_q   <= 4'd0;
            plen_q  <= 4'd0;
            len_q   <= 4'd0;
            swap_q  <= 1'b0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                front_q[i] <= Blank;
                back_q[i]  <= Blank;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            plen_q  <= plen_d;
            len_q   <= len_d;
            swap_q  <= swap_d;
            ovf_q   <= ovf_d;
            front_q <= front_d;
            back_q  <= back_d;
        end
    end

    assign char_ready_out = (state_q == StFill);
    assign busy_out       = (state_q == StPending);
    assign swap_out       = swap_q;
    assign overflow_out   = ovf_q;
    assign word_len_out   = len_q;
    assign word_out       = front_q;

endmodule

// File: tb/tb_word_buffer_ctrl.sv
// Scoreboard bench for word_buffer_ctrl: a word-level model queues expected swaps, a monitor checks them.
module tb_word_buffer_ctrl;

    localparam int          N         = 10;
    localparam logic [5:0]  BL        = 6'd63;
    localparam int unsigned FRAME     = 1024;
    localparam int unsigned MATCH_POS = 768;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [5:0]  char_in;
    logic        char_valid_in;
    logic        char_ready_out;
    logic        commit_in;
    logic [5:0]  word_out [N-1:0];
    logic [3:0]  word_len_out;
    logic        busy_out;
    logic        swap_out;
    logic        overflow_out;

    word_buffer_ctrl dut (
        .pixel_clk_in   (clk),
        .rst_n_in       (rst_n),
        .hcount_in      (hcount),
        .vcount_in      (vcount),
        .char_in        (char_in),
        .char_valid_in  (char_valid_in),
        .char_ready_out (char_ready_out),
        .commit_in      (commit_in),
        .word_out       (word_out),
        .word_len_out   (word_len_out),
        .busy_out       (busy_out),
        .swap_out       (swap_out),
        .overflow_out   (overflow_out)
    );

    always #5 clk = ~clk;

    // Edge counter; inputs seen at edge k+1 come from raster position k % FRAME.
    int unsigned ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    // Compressed raster: 8 lines of 128 pixels, line 6 is vcount 720.
    function automatic logic [9:0] vsel(input int unsigned line);
        case (line)
            0: vsel = 10'd8;
            1: vsel = 10'd9;
            2: vsel = 10'd10;
            3: vsel = 10'd11;
            4: vsel = 10'd718;
            5: vsel = 10'd719;
            6: vsel = 10'd720;
            default: vsel = 10'd721;
        endcase
    endfunction

    assign hcount = 11'(ecnt % 128);
    assign vcount = vsel((ecnt % FRAME) / 128);

    typedef struct packed {
        logic [N-1:0][5:0] w;
        logic [3:0]        len;
        logic [31:0]       edge_n;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nerr = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", nm, act, exp, ecnt);
        end
    endfunction

    function automatic logic [N-1:0][5:0] flat_word();
        logic [N-1:0][5:0] f;
        for (int i = 0; i < N; i++) f[i] = word_out[i];
        return f;
    endfunction

    // Word-level model
    logic [5:0]  mbuf [N];
    int          mlen;
    bit          mov;
    int unsigned swap_edge;

    function automatic logic [N-1:0][5:0] all_blank();
        logic [N-1:0][5:0] f;
        for (int i = 0; i < N; i++) f[i] = BL;
        return f;
    endfunction

    task automatic step(input bit v, input logic [5:0] c, input bit cm);
        bit   pend;
        bit   cmx;
        exp_t e;
        int unsigned d;
        @(posedge clk);
        #1;
        pend = (ecnt < swap_edge);
        chk("ready", 64'(char_ready_out), 64'(!pend));
        chk("busy", 64'(busy_out), 64'(pend));
        chk("overflow", 64'(overflow_out), 64'(mov));
        if (!pend) begin
            cmx = cm;
            if (v) begin
                if (mlen < N) begin
                    mbuf[mlen] = c;
                    mlen++;
`ifdef WORD_AUTO_COMMIT_EN
                    if (mlen == N) cmx = 1'b1;
`endif
                end else begin
                    mov = 1'b1;
                end
            end
            if (cmx) begin
                for (int i = 0; i < N; i++) e.w[i] = (i < mlen) ? mbuf[i] : BL;
                e.len = 4'(mlen);
                d = (MATCH_POS + FRAME - (ecnt % FRAME)) % FRAME;
                if (d == 0) d = FRAME;
                e.edge_n  = 32'(ecnt + 1 + d);
                swap_edge = ecnt + 1 + d;
                q.push_back(e);
                mlen = 0;
            end
        end
        char_valid_in = v;
        char_in       = c;
        commit_in     = cm;
    endtask

    task automatic wait_pos(input int unsigned p);
        for (int i = 0; i < int'(FRAME); i++) begin
            if (((ecnt + 1) % FRAME) == p) break;
            step(1'b0, 6'd0, 1'b0);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < int'(2 * FRAME + 4); i++) begin
            if (ecnt > swap_edge) break;
            step(1'b0, 6'd0, 1'b0);
        end
        step(1'b0, 6'd0, 1'b0);
    endtask

    task automatic reset_checks();
        chk("rst_word", 64'(flat_word()), 64'(all_blank()));
        chk("rst_len", 64'(word_len_out), 64'(0));
        chk("rst_busy", 64'(busy_out), 64'(0));
        chk("rst_swap", 64'(swap_out), 64'(0));
        chk("rst_overflow", 64'(overflow_out), 64'(0));
    endtask

    task automatic model_reset();
        mlen      = 0;
        mov       = 1'b0;
        swap_edge = 0;
        q.delete();
    endtask

    // Monitor: pops the scoreboard on each swap pulse and tracks the displayed word.
    logic [N-1:0][5:0] cw;
    logic [3:0]        cl;
    always @(negedge clk) begin
        if (!rst_n) begin
            cw = all_blank();
            cl = 4'd0;
        end else begin
            if (swap_out) begin
                if (q.size() == 0) begin
                    chk("spurious_swap", 64'(swap_out), 64'(0));
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("swap_edge", 64'(ecnt), 64'(e.edge_n));
                    cw = e.w;
                    cl = e.len;
                end
            end else if (q.size() > 0 && ecnt >= q[0].edge_n) begin
                chk("missed_swap", 64'(swap_out), 64'(1));
                void'(q.pop_front());
            end
            chk("word_len", 64'(word_len_out), 64'(cl));
            chk("word", 64'(flat_word()), 64'(cw));
        end
    end

    initial begin
        char_valid_in = 1'b0;
        char_in       = 6'd0;
        commit_in     = 1'b0;
        rst_n         = 1'b1;
        cw            = all_blank();
        cl            = 4'd0;
        model_reset();
        #1 rst_n = 1'b0;
        #1 reset_checks();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle two frames: blank word, never swaps.
        repeat (2 * FRAME) step(1'b0, 6'd0, 1'b0);

        // Word 1,2,3 committed at hcount 100 / vcount 10.
        step(1'b1, 6'd1, 1'b0);
        step(1'b1, 6'd2, 1'b0);
        step(1'b1, 6'd3, 1'b0);
        wait_pos(356);
        step(1'b0, 6'd0, 1'b1);
        drain();

        // Twelve codes: overflow (or auto-commit), then an explicit commit.
        for (int i = 0; i < 12; i++) step(1'b1, 6'(i), 1'b0);
        step(1'b0, 6'd0, 1'b0);
        step(1'b0, 6'd0, 1'b1);
        drain();
        step(1'b0, 6'd0, 1'b1);
        drain();

        // Char and commit in the same cycle.
        step(1'b1, 6'd5, 1'b1);
        drain();

        // Commit on the exact swap-point cycle waits a full frame.
        wait_pos(MATCH_POS);
        step(1'b1, 6'd7, 1'b1);
        drain();

        // Reset while a swap is pending.
        step(1'b1, 6'd9, 1'b0);
        step(1'b0, 6'd0, 1'b1);
        repeat (20) step(1'b0, 6'd0, 1'b0);
        #2 rst_n = 1'b0;
        char_valid_in = 1'b0;
        commit_in     = 1'b0;
        model_reset();
        #1 reset_checks();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (FRAME + 10) step(1'b0, 6'd0, 1'b0);

        // Random traffic.
        repeat (15000) step(($urandom % 4) != 0, 6'($urandom), ($urandom % 16) == 0);
        repeat (FRAME + 4) step(1'b0, 6'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
